// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch FSM with branch/jump redirect and misaligned-target rejection
module fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic        jump,
  input  logic [31:0] target_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        misaligned
);
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;
  state_t      r_state;
  logic [31:0] r_fetch_pc;
  logic        r_drop;
  logic        w_redir_req;
  logic        w_aligned;
  logic        w_eval;
  logic        w_redirect;
  logic [31:0] w_fetch_pc_inc;
  assign w_redir_req    = branch_taken | jump;
  assign w_aligned      = target_addr[1:0] == 2'b00;
  assign w_eval         = (r_state == S_HOLD) & ~stall;
  assign w_redirect     = w_eval & w_redir_req & w_aligned;
  assign w_fetch_pc_inc = r_fetch_pc + 32'd4;
  assign imem_addr      = r_fetch_pc;
  assign pc_plus4       = pc + 32'd4;
  // fetch FSM; a reset while a response is still owed arms drop so that stale data is discarded
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_fetch_pc  <= RESET_VECTOR;
      r_drop      <= ((r_state == S_WAIT) | r_drop) & ~imem_rvalid;
      instr_valid <= 1'b0;
      instr       <= 32'h0000_0013;
      pc          <= RESET_VECTOR;
      misaligned  <= 1'b0;
      imem_req    <= 1'b0;
    end else begin
      misaligned <= w_eval & w_redir_req & ~w_aligned;
      if (imem_rvalid & r_drop) r_drop <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_state  <= S_REQ;
          imem_req <= 1'b1;
        end
        S_REQ: if (imem_ready) begin
          r_state  <= S_WAIT;
          imem_req <= 1'b0;
        end
        S_WAIT: if (imem_rvalid & ~r_drop) begin
          instr       <= imem_rdata;
          pc          <= r_fetch_pc;
          instr_valid <= 1'b1;
          r_fetch_pc  <= w_fetch_pc_inc;
          r_state     <= S_HOLD;
        end
        S_HOLD: if (!stall) begin
          instr_valid <= 1'b0;
          r_state     <= S_REQ;
          imem_req    <= 1'b1;
          if (w_redirect) r_fetch_pc <= target_addr;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit with a memory responder and instruction monitor
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst, stall, branch_taken, jump, imem_ready, imem_rvalid;
  logic [31:0] target_addr, imem_rdata;
  logic        imem_req, instr_valid, misaligned;
  logic [31:0] imem_addr, instr, pc, pc_plus4;
  int          checks = 0;
  int          errors = 0;
  int          n_ins = 0;
  bit          mem_auto = 1'b1;
  bit          acc = 1'b0;
  bit          prev_v = 1'b0;
  logic [31:0] acc_addr = 32'h0;
  logic [31:0] exp_addr[$];
  logic [31:0] exp_pc[$];

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken), .jump(jump),
    .target_addr(target_addr), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .pc(pc), .pc_plus4(pc_plus4),
    .misaligned(misaligned)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b expected=%b", name, act, exp);
    end
  endtask

  task automatic wait_hold(input logic [31:0] a);
    int k;
    k = 0;
    while (!(instr_valid === 1'b1 && pc === a) && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) begin
      checks++;
      errors++;
      $display("FAIL hold_timeout pc actual=%h expected=%h", pc, a);
    end
  endtask

  // memory responder: accept when req&ready, return data the following cycle, check request address
  always @(negedge clk) begin
    #1;
    if (mem_auto) begin
      imem_rvalid = acc;
      imem_rdata  = acc ? mem_word(acc_addr) : 32'h0;
      acc         = imem_req && imem_ready;
      acc_addr    = imem_addr;
      if (acc) begin
        if (exp_addr.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_req actual=%h expected=none", imem_addr);
        end else chk("req_addr", imem_addr, exp_addr.pop_front());
      end
    end else acc = 1'b0;
  end

  // instruction monitor: each new instr_valid must match the next expected pc
  always @(posedge clk) begin
    logic [31:0] e;
    #1;
    if (instr_valid && !prev_v) begin
      if (exp_pc.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_instr actual=%h expected=none", pc);
      end else begin
        e = exp_pc.pop_front();
        chk("instr_pc", pc, e);
        chk("instr_word", instr, mem_word(e));
        chk("pc_plus4", pc_plus4, e + 32'd4);
      end
      n_ins++;
    end
    prev_v = instr_valid;
  end

  initial begin
    int k;
    rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; jump = 1'b0; target_addr = 32'h0;
    imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    repeat (3) @(negedge clk);
    chkb("rst_valid", instr_valid, 1'b0);
    chk("rst_instr", instr, 32'h0000_0013);
    chk("rst_pc", pc, 32'h0);
    chk("rst_pc4", pc_plus4, 32'h4);
    chkb("rst_mis", misaligned, 1'b0);
    chkb("rst_req", imem_req, 1'b0);
    foreach (exp_addr[i]) exp_addr.delete(i);
    exp_addr.push_back(32'h0); exp_addr.push_back(32'h4); exp_addr.push_back(32'h8); exp_addr.push_back(32'hC);
    exp_pc.push_back(32'h0); exp_pc.push_back(32'h4); exp_pc.push_back(32'h8); exp_pc.push_back(32'hC);
    rst = 1'b0;
    chkb("idle_req", imem_req, 1'b0);
    @(negedge clk);
    chkb("first_req", imem_req, 1'b1);
    chk("first_addr", imem_addr, 32'h0);
    // stall in HOLD with a redirect request that must be ignored
    wait_hold(32'h8);
    stall = 1'b1; branch_taken = 1'b1; target_addr = 32'h200;
    repeat (3) begin
      @(negedge clk);
      chkb("stall_valid", instr_valid, 1'b1);
      chk("stall_pc", pc, 32'h8);
      chk("stall_instr", instr, mem_word(32'h8));
      chkb("stall_req", imem_req, 1'b0);
      chkb("stall_mis", misaligned, 1'b0);
    end
    stall = 1'b0; branch_taken = 1'b0;
    // taken branch
    wait_hold(32'hC);
    exp_addr.push_back(32'h100); exp_pc.push_back(32'h100);
    branch_taken = 1'b1; target_addr = 32'h100;
    @(negedge clk);
    branch_taken = 1'b0;
    chkb("br_req", imem_req, 1'b1);
    chk("br_addr", imem_addr, 32'h100);
    chkb("br_valid", instr_valid, 1'b0);
    // misaligned jump
    wait_hold(32'h100);
    exp_addr.push_back(32'h104); exp_pc.push_back(32'h104);
    jump = 1'b1; target_addr = 32'h102;
    @(negedge clk);
    jump = 1'b0;
    chkb("mis_pulse", misaligned, 1'b1);
    chk("mis_addr", imem_addr, 32'h104);
    @(negedge clk);
    chkb("mis_clear", misaligned, 1'b0);
    // jump to the top of the address space, then wrap
    wait_hold(32'h104);
    exp_addr.push_back(32'hFFFF_FFFC); exp_pc.push_back(32'hFFFF_FFFC);
    exp_addr.push_back(32'h0); exp_pc.push_back(32'h0);
    exp_addr.push_back(32'h4); exp_pc.push_back(32'h4);
    jump = 1'b1; target_addr = 32'hFFFF_FFFC;
    @(negedge clk);
    jump = 1'b0;
    wait_hold(32'hFFFF_FFFC);
    chk("wrap_pc4", pc_plus4, 32'h0);
    @(negedge clk);
    chk("wrap_addr", imem_addr, 32'h0);
    jump = 1'b1; target_addr = 32'h300;
    @(negedge clk);
    @(negedge clk);
    jump = 1'b0; imem_ready = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chkb("noready_req", imem_req, 1'b1);
      chk("noready_addr", imem_addr, 32'h4);
    end
    imem_ready = 1'b1;
    // reset while waiting on a response; stale data arrives during the new fetch
    wait_hold(32'h4);
    mem_auto = 1'b0; imem_rvalid = 1'b0;
    @(negedge clk);
    chk("pre_rst_addr", imem_addr, 32'h8);
    @(negedge clk);
    chkb("pre_rst_wait", imem_req, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst2_instr", instr, 32'h0000_0013);
    chk("rst2_pc", pc, 32'h0);
    @(negedge clk);
    chkb("rst2_req", imem_req, 1'b1);
    chk("rst2_addr", imem_addr, 32'h0);
    exp_pc.push_back(32'h0);
    @(negedge clk);
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_rvalid = 1'b0;
    chkb("drop_valid", instr_valid, 1'b0);
    @(negedge clk);
    imem_rvalid = 1'b1; imem_rdata = mem_word(32'h0);
    @(negedge clk);
    imem_rvalid = 1'b0;
    wait_hold(32'h0);
    k = 0;
    while ((exp_pc.size() != 0 || exp_addr.size() != 0) && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("pc_queue_left", exp_pc.size(), 32'h0);
    chk("addr_queue_left", exp_addr.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
